wb_sram_rr_arbiter: RTL and testbench



---
 rtl/wb_sram_rr_arbiter.sv | 141 ++++++++++++++
 tb/tb_wb_sram_rr_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_rr_arbiter.sv
// Round-robin arbiter sharing the weight-buffer SRAM read port.
// Optional watchdog abort enabled by defining WB_ARB_TIMEOUT_EN.
module wb_sram_rr_arbiter #(
    parameter int NUM_CH         = 4,
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int NR            = 3 * NUM_CH,
    localparam int GW            = $clog2(NR)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NR-1:0]        req_read,
    input  logic [NR*ADDR_W-1:0] req_word_counter,
    input  logic [ADDR_W-1:0]    idx_start_address,
    input  logic [ADDR_W-1:0]    unique_start_address,
    input  logic [ADDR_W-1:0]    repetition_start_address,
    output logic [NR-1:0]        req_ready,
    output logic                 SRAM_read,
    output logic [ADDR_W-1:0]    SRAM_address,
    input  logic                 SRAM_ready,
    output logic                 busy,
    output logic [GW-1:0]        grant_id,
    output logic                 timeout_err
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [GW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              win_found;
    logic [GW-1:0]     win_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [ADDR_W-1:0] base;
    logic [GW-1:0]     jj;
    logic [GW-1:0]     next_ptr;
    logic              done;
    logic              abort;
    int                j;

    // Scan from rr_ptr, wrapping; first set request wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        win_addr  = '0;
        base      = '0;
        jj        = '0;
        j         = 0;
        for (int i = 0; i < NR; i++) begin
            j = int'(rr_ptr_q) + i;
            if (j >= NR) j = j - NR;
            jj = GW'(j);
            if (j < NUM_CH)          base = idx_start_address;
            else if (j < 2 * NUM_CH) base = unique_start_address;
            else                     base = repetition_start_address;
            if (!win_found && req_read[jj]) begin
                win_found = 1'b1;
                win_idx   = jj;
                win_addr  = base + req_word_counter[j*ADDR_W +: ADDR_W];
            end
        end
    end

    assign next_ptr = (grant_q == GW'(NR - 1)) ? '0 : grant_q + 1'b1;
    assign done     = (state_q == BUSY) && SRAM_ready;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;

    // Abort on the last allowed BUSY cycle without data.
    assign abort = (state_q == BUSY) && !SRAM_ready &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        err_d = err_q;
        if (state_q == IDLE)  tmo_d = '0;
        else if (!SRAM_ready) tmo_d = tmo_q + 1'b1;
        if (abort)            err_d = 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end

    assign timeout_err = err_q;
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        if (state_q == IDLE) begin
            if (win_found) begin
                grant_d = win_idx;
                addr_d  = win_addr;
                state_d = BUSY;
            end
        end else if (done || abort) begin
            rr_ptr_d = next_ptr;
            state_d  = IDLE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            addr_q   <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
        end
    end

    assign SRAM_read    = (state_q == BUSY);
    assign busy         = (state_q == BUSY);
    assign SRAM_address = addr_q;
    assign grant_id     = grant_q;
    assign req_ready    = done ? (NR'(1) << grant_q) : '0;

endmodule

// File: tb/tb_wb_sram_rr_arbiter.sv
// Directed self-checking bench for wb_sram_rr_arbiter.
// Timeout steps run only when WB_ARB_TIMEOUT_EN is defined.
module tb_wb_sram_rr_arbiter;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 32;
    localparam int NR     = 3 * NUM_CH;
    localparam int GW     = $clog2(NR);

    logic                 clock;
    logic                 reset;
    logic [NR-1:0]        req_read;
    logic [NR*ADDR_W-1:0] req_word_counter;
    logic [ADDR_W-1:0]    idx_start_address;
    logic [ADDR_W-1:0]    unique_start_address;
    logic [ADDR_W-1:0]    repetition_start_address;
    logic [NR-1:0]        req_ready;
    logic                 SRAM_read;
    logic [ADDR_W-1:0]    SRAM_address;
    logic                 SRAM_ready;
    logic                 busy;
    logic [GW-1:0]        grant_id;
    logic                 timeout_err;

    int n_chk;
    int n_fail;

    wb_sram_rr_arbiter #(
        .NUM_CH(NUM_CH),
        .ADDR_W(ADDR_W),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .req_read(req_read),
        .req_word_counter(req_word_counter),
        .idx_start_address(idx_start_address),
        .unique_start_address(unique_start_address),
        .repetition_start_address(repetition_start_address),
        .req_ready(req_ready),
        .SRAM_read(SRAM_read),
        .SRAM_address(SRAM_address),
        .SRAM_ready(SRAM_ready),
        .busy(busy),
        .grant_id(grant_id),
        .timeout_err(timeout_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cnt(input int r, input logic [ADDR_W-1:0] v);
        req_word_counter[r*ADDR_W +: ADDR_W] = v;
    endtask

    task automatic chk_busy(input string tag, input logic [GW-1:0] g,
                            input logic [ADDR_W-1:0] a);
        chk({tag, "_read"}, 64'(SRAM_read), 64'd1);
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        chk({tag, "_gnt"}, 64'(grant_id), 64'(g));
        chk({tag, "_addr"}, 64'(SRAM_address), 64'(a));
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_read"}, 64'(SRAM_read), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_rdy"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1;
        req_read = '0;
        req_word_counter = '0;
        idx_start_address = '0;
        unique_start_address = '0;
        repetition_start_address = '0;
        SRAM_ready = 1'b0;
        #1 reset = 1'b0;
        #1;
        chk_idle("rst");
        chk("rst_gnt", 64'(grant_id), 64'd0);
        chk("rst_addr", 64'(SRAM_address), 64'd0);
        chk("rst_err", 64'(timeout_err), 64'd0);
        step();
        #2 reset = 1'b1;

        // Single request, class 1 ch 1, ready after 3 busy cycles
        unique_start_address = 32'h1000;
        set_cnt(5, 32'd7);
        req_read[5] = 1'b1;
        step();
        chk_busy("t1", 4'd5, 32'h1007);
        chk("t1_rdy0", 64'(req_ready), 64'd0);
        step();
        step();
        chk_busy("t1b", 4'd5, 32'h1007);
        step();
        chk("t1_rdy3", 64'(req_ready), 64'd0);
        SRAM_ready = 1'b1;
        #1 chk("t1_strobe", 64'(req_ready), 64'h020);
        req_read = '0;
        step();
        SRAM_ready = 1'b0;
        #1 chk_idle("t1_idle");

        // Reset, then round-robin over bits 0, 4, 8
        reset = 1'b0;
        #1 reset = 1'b1;
        idx_start_address = 32'h100;
        repetition_start_address = 32'h2000;
        set_cnt(0, 32'h10);
        set_cnt(4, 32'h20);
        set_cnt(8, 32'h30);
        req_read[0] = 1'b1;
        req_read[4] = 1'b1;
        req_read[8] = 1'b1;
        SRAM_ready = 1'b1;
        step();
        chk_busy("rr0", 4'd0, 32'h110);
        chk("rr0_rdy", 64'(req_ready), 64'h001);
        step();
        chk_idle("rr0_idle");
        step();
        chk_busy("rr4", 4'd4, 32'h1020);
        chk("rr4_rdy", 64'(req_ready), 64'h010);
        step();
        chk_idle("rr4_idle");
        step();
        chk_busy("rr8", 4'd8, 32'h2030);
        chk("rr8_rdy", 64'(req_ready), 64'h100);
        step();
        chk_idle("rr8_idle");
        step();
        chk_busy("rr0b", 4'd0, 32'h110);
        chk("rr0b_rdy", 64'(req_ready), 64'h001);
        req_read = '0;
        step();
        SRAM_ready = 1'b0;

        // Address wrap modulo 2^32
        idx_start_address = 32'hFFFF_FFFE;
        set_cnt(1, 32'd5);
        req_read[1] = 1'b1;
        step();
        chk_busy("wrap", 4'd1, 32'h0000_0003);
        SRAM_ready = 1'b1;
        #1 chk("wrap_rdy", 64'(req_ready), 64'h002);
        req_read = '0;
        step();
        SRAM_ready = 1'b0;
        step();
        chk_idle("noreq");

        // Requester 3 drops request mid-transaction
        idx_start_address = 32'h40;
        set_cnt(3, 32'd2);
        req_read[3] = 1'b1;
        step();
        chk_busy("drop", 4'd3, 32'h42);
        req_read[3] = 1'b0;
        set_cnt(3, 32'd9);
        for (int i = 0; i < 4; i++) begin
            step();
            chk_busy("drop_hold", 4'd3, 32'h42);
            chk("drop_rdy0", 64'(req_ready), 64'd0);
        end
        SRAM_ready = 1'b1;
        #1 chk("drop_strobe", 64'(req_ready), 64'h008);
        step();
        SRAM_ready = 1'b0;

        // Pointer at 4: bit 5 beats bit 3; held bit 3 follows
        set_cnt(5, 32'd7);
        req_read[3] = 1'b1;
        req_read[5] = 1'b1;
        step();
        chk_busy("ord5", 4'd5, 32'h1007);
        SRAM_ready = 1'b1;
        #1 chk("ord5_rdy", 64'(req_ready), 64'h020);
        step();
        chk_idle("ord_idle");
        step();
        chk_busy("ord3", 4'd3, 32'h49);
        chk("ord3_rdy", 64'(req_ready), 64'h008);
        req_read = '0;
        step();
        SRAM_ready = 1'b0;

        // Asynchronous reset in the middle of BUSY
        set_cnt(7, 32'd0);
        req_read[7] = 1'b1;
        step();
        chk_busy("ar", 4'd7, 32'h1000);
        SRAM_ready = 1'b1;
        #1 chk("ar_rdy", 64'(req_ready), 64'h080);
        #1 reset = 1'b0;
        #1;
        chk_idle("ar_rst");
        chk("ar_gnt", 64'(grant_id), 64'd0);
        chk("ar_addr", 64'(SRAM_address), 64'd0);
        #1 reset = 1'b1;
        req_read = '0;
        SRAM_ready = 1'b0;
        set_cnt(2, 32'd3);
        req_read[2] = 1'b1;
        req_read[7] = 1'b1;
        step();
        chk_busy("ar_post", 4'd2, 32'h43);
        SRAM_ready = 1'b1;
        #1 chk("ar_post_rdy", 64'(req_ready), 64'h004);
        req_read = '0;
        step();
        SRAM_ready = 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
        // Watchdog abort after 8 BUSY cycles, then bit 10 granted
        repetition_start_address = 32'h2000;
        set_cnt(9, 32'd1);
        set_cnt(10, 32'd2);
        req_read[9] = 1'b1;
        req_read[10] = 1'b1;
        step();
        chk_busy("to9", 4'd9, 32'h2001);
        for (int i = 1; i < 8; i++) begin
            step();
            chk("to_busy", 64'(busy), 64'd1);
            chk("to_rdy0", 64'(req_ready), 64'd0);
            chk("to_err0", 64'(timeout_err), 64'd0);
        end
        step();
        chk_idle("to_abort");
        chk("to_err1", 64'(timeout_err), 64'd1);
        step();
        chk_busy("to10", 4'd10, 32'h2002);
        SRAM_ready = 1'b1;
        #1 chk("to10_rdy", 64'(req_ready), 64'h400);
        req_read = '0;
        step();
        SRAM_ready = 1'b0;
        step();
        chk("to_err_held", 64'(timeout_err), 64'd1);
`else
        chk("no_tmo_err", 64'(timeout_err), 64'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
